// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
package mux_arb_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

endpackage

// File: rtl/mux_2_1_bus.sv
// Bussed 2:1 mux carrying {data,last,valid} of one stream beat.
module mux_2_1_bus
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              sel_i,
    input  logic [DATA_W-1:0] in0_data_i,
    input  logic              in0_last_i,
    input  logic              in0_valid_i,
    input  logic [DATA_W-1:0] in1_data_i,
    input  logic              in1_last_i,
    input  logic              in1_valid_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              out_valid_o
);

    localparam int unsigned BUS_W = DATA_W + 2;

    logic [BUS_W-1:0] bus0;
    logic [BUS_W-1:0] bus1;
    logic [BUS_W-1:0] bus_out;

    assign bus0 = {in0_data_i, in0_last_i, in0_valid_i};
    assign bus1 = {in1_data_i, in1_last_i, in1_valid_i};

    // Select the whole beat as one bus.
    always_comb begin
        bus_out = sel_i ? bus1 : bus0;
    end

    assign out_data_o  = bus_out[BUS_W-1:2];
    assign out_last_o  = bus_out[1];
    assign out_valid_o = bus_out[0];

endmodule

// File: rtl/mux_2_1_rr_arbiter.sv
// Round-robin arbiter sharing one stream output between two requesters.
// Grant lasts a packet, capped at MAX_BURST beats while the other side waits.
module mux_2_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              sel,
    output logic              busy
);

    localparam int unsigned       CNT_W   = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             mux_valid;
    logic             mux_last;
    logic [DATA_W-1:0] mux_data;
    logic             beat;
    logic             other_valid;
    logic             cnt_sat;
    logic             pick;

    mux_2_1_bus #(.DATA_W(DATA_W)) u_bus (
        .sel_i       (sel_q),
        .in0_data_i  (s0_data),
        .in0_last_i  (s0_last),
        .in0_valid_i (s0_valid),
        .in1_data_i  (s1_data),
        .in1_last_i  (s1_last),
        .in1_valid_i (s1_valid),
        .out_data_o  (mux_data),
        .out_last_o  (mux_last),
        .out_valid_o (mux_valid)
    );

    // Output channel follows the registered select; valid only while granted.
    assign m_valid  = busy_q & mux_valid;
    assign m_data   = mux_data;
    assign m_last   = mux_last;
    assign s0_ready = (state_q == GRANT0) & m_ready;
    assign s1_ready = (state_q == GRANT1) & m_ready;
    assign sel      = sel_q;
    assign busy     = busy_q;

    assign beat        = m_valid & m_ready;
    assign other_valid = sel_q ? s0_valid : s1_valid;
    assign cnt_sat     = (beat_cnt_q == CNT_SAT);

    // Grant decision, packet/burst end handling and beat counting.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        pick         = 1'b0;
        unique case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (s0_valid | s1_valid) begin
                    pick    = (s0_valid & s1_valid) ? ~last_grant_q : s1_valid;
                    sel_d   = pick;
                    state_d = pick ? GRANT1 : GRANT0;
                end
            end
            GRANT0, GRANT1: begin
                if (beat) begin
                    if ((mux_last | cnt_sat) & other_valid) begin
                        sel_d        = ~sel_q;
                        state_d      = sel_q ? GRANT0 : GRANT1;
                        beat_cnt_d   = '0;
                        last_grant_d = sel_q;
                    end else if (mux_last) begin
                        state_d      = IDLE;
                        beat_cnt_d   = '0;
                        last_grant_d = sel_q;
                    end else if (!cnt_sat) begin
                        beat_cnt_d   = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, select, fairness pointer and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_2_1_rr_arbiter.sv
// Bench for mux_2_1_rr_arbiter: per-cycle model compare plus directed sequences.
module tb_mux_2_1_rr_arbiter;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic              clk;
    logic              rst_n;
    logic              s0_valid, s0_last, s0_ready;
    logic [DATA_W-1:0] s0_data;
    logic              s1_valid, s1_last, s1_ready;
    logic [DATA_W-1:0] s1_data;
    logic              m_valid, m_last, m_ready;
    logic [DATA_W-1:0] m_data;
    logic              sel, busy;

    mux_2_1_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_last  (s0_last),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_last  (s1_last),
        .s1_ready (s1_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .sel      (sel),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Source stimulus state
    int   len   [2];
    int   total [2];
    int   sent  [2];
    bit   en    [2];
    logic mr;

    // Beats seen on the output
    logic [7:0] log_q    [$];
    logic       log_last [$];
    int         log_cyc  [$];
    int         cyc = 0;

    // Snapshot of outputs taken late in each cycle
    logic       snap_busy, snap_sel, snap_mvalid, snap_r0, snap_r1;
    logic [7:0] snap_mdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic src_v(input int o);
        return (o == 1) ? s1_valid : s0_valid;
    endfunction
    function automatic logic src_l(input int o);
        return (o == 1) ? s1_last : s0_last;
    endfunction
    function automatic logic [7:0] src_d(input int o);
        return (o == 1) ? s1_data : s0_data;
    endfunction

    // Behavioural model: owner (-1 none), beats in current grant, previous holder.
    int mo_owner;
    int mo_run;
    int mo_prev;
    bit mo_sel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mo_owner <= -1;
            mo_run   <= 0;
            mo_prev  <= 1;
            mo_sel   <= 1'b0;
        end else if (mo_owner == -1) begin
            if (s0_valid && s1_valid) begin
                mo_owner <= 1 - mo_prev;
                mo_sel   <= (mo_prev == 0);
            end else if (s0_valid) begin
                mo_owner <= 0;
                mo_sel   <= 1'b0;
            end else if (s1_valid) begin
                mo_owner <= 1;
                mo_sel   <= 1'b1;
            end
        end else if (src_v(mo_owner) && m_ready) begin
            if ((src_l(mo_owner) || (mo_run + 1 >= MAX_BURST)) && src_v(1 - mo_owner)) begin
                mo_owner <= 1 - mo_owner;
                mo_sel   <= (mo_owner == 0);
                mo_run   <= 0;
                mo_prev  <= mo_owner;
            end else if (src_l(mo_owner)) begin
                mo_owner <= -1;
                mo_run   <= 0;
                mo_prev  <= mo_owner;
            end else begin
                mo_run   <= mo_run + 1;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("busy", 32'(busy), 32'(mo_owner != -1));
            check("sel", 32'(sel), 32'(mo_sel));
            check("m_valid", 32'(m_valid), 32'((mo_owner != -1) && src_v(mo_owner)));
            check("s0_ready", 32'(s0_ready), 32'((mo_owner == 0) && m_ready));
            check("s1_ready", 32'(s1_ready), 32'((mo_owner == 1) && m_ready));
            if (mo_owner != -1) begin
                check("m_data", 32'(m_data), 32'(src_d(mo_owner)));
                check("m_last", 32'(m_last), 32'(src_l(mo_owner)));
            end
        end
    end

    task automatic drive();
        s0_valid = en[0] && (sent[0] < total[0]);
        s0_data  = 8'(sent[0]);
        s0_last  = ((sent[0] % len[0]) == len[0] - 1);
        s1_valid = en[1] && (sent[1] < total[1]);
        s1_data  = 8'(sent[1]) | 8'h80;
        s1_last  = ((sent[1] % len[1]) == len[1] - 1);
        m_ready  = mr;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit rst_mid);
        bit h0, h1;
        drive();
        #3;
        if (rst_mid) rst_n = 1'b0;
        #1;
        snap_busy   = busy;
        snap_sel    = sel;
        snap_mvalid = m_valid;
        snap_mdata  = m_data;
        snap_r0     = s0_ready;
        snap_r1     = s1_ready;
        h0 = s0_valid && s0_ready;
        h1 = s1_valid && s1_ready;
        if (m_valid && m_ready) begin
            log_q.push_back(m_data);
            log_last.push_back(m_last);
            log_cyc.push_back(cyc);
        end
        @(negedge clk);
        if (h0) sent[0]++;
        if (h1) sent[1]++;
        cyc++;
    endtask

    task automatic run_until(input string nm, input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            step(1'b0);
            k++;
        end
        check(nm, 32'(log_q.size()), 32'(n));
    endtask

    task automatic check_seq(input string nm, input logic [7:0] exp_q [$]);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", nm, i),
                  (i < log_q.size()) ? 32'(log_q[i]) : 32'hdead, 32'(exp_q[i]));
        end
    endtask

    task automatic setup(input int l0, input int t0, input bit e0,
                         input int l1, input int t1, input bit e1);
        len[0] = l0; total[0] = t0; en[0] = e0; sent[0] = 0;
        len[1] = l1; total[1] = t1; en[1] = e1; sent[1] = 0;
        log_q.delete(); log_last.delete(); log_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        rst_n = 1'b0;
        mr    = 1'b1;
        setup(1, 0, 1'b0, 1, 0, 1'b0);
        drive();
        @(negedge clk);

        // Reset held with both requesters valid; then alternating 2-beat packets.
        setup(2, 6, 1'b1, 2, 6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check("rst_busy", 32'(snap_busy), 32'(0));
            check("rst_mvalid", 32'(snap_mvalid), 32'(0));
        end
        rst_n = 1'b1;
        step(1'b0);
        check("rel_busy", 32'(snap_busy), 32'(0));
        step(1'b0);
        check("grant0_busy", 32'(snap_busy), 32'(1));
        check("grant0_sel", 32'(snap_sel), 32'(0));
        run_until("alt_done", 12, 40);
        exp_q = {8'h00, 8'h01, 8'h80, 8'h81, 8'h02, 8'h03,
                 8'h82, 8'h83, 8'h04, 8'h05, 8'h84, 8'h85};
        check_seq("alt_seq", exp_q);
        if (log_cyc.size() == 12)
            check("alt_no_gap", 32'(log_cyc[11] - log_cyc[0]), 32'(11));

        // s0 alone sends a 3-beat packet, then arbiter returns to idle.
        do_reset();
        setup(3, 3, 1'b1, 1, 0, 1'b0);
        run_until("solo_done", 3, 20);
        step(1'b0);
        exp_q = {8'h00, 8'h01, 8'h02};
        check_seq("solo_seq", exp_q);
        if (log_last.size() == 3) begin
            check("solo_last1", 32'(log_last[1]), 32'(0));
            check("solo_last2", 32'(log_last[2]), 32'(1));
        end
        check("solo_idle", 32'(snap_busy), 32'(0));

        // Long s0 packet is split after MAX_BURST beats while s1 waits.
        do_reset();
        setup(20, 20, 1'b1, 2, 2, 1'b1);
        run_until("burst_done", 22, 60);
        exp_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h04, 8'h05};
        check_seq("burst_seq", exp_q);
        if (log_q.size() == 22) begin
            check("burst_end", 32'(log_q[21]), 32'h13);
            check("burst_split_nolast", 32'(log_last[3]), 32'(0));
        end

        // Downstream stall mid-packet: data held, count frozen, no switch.
        do_reset();
        setup(6, 6, 1'b1, 2, 2, 1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        mr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            check("stall_data", 32'(snap_mdata), 32'h02);
            check("stall_r0", 32'(snap_r0), 32'(0));
            check("stall_sel", 32'(snap_sel), 32'(0));
        end
        mr = 1'b1;
        run_until("stall_done", 8, 30);
        exp_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h04, 8'h05};
        check_seq("stall_seq", exp_q);

        // Reset asserted during an s1 burst; s0 wins the restart.
        do_reset();
        setup(2, 2, 1'b0, 6, 6, 1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        en[0] = 1'b1;
        step(1'b0);
        step(1'b1);
        check("mid_rst_busy", 32'(snap_busy), 32'(0));
        check("mid_rst_sel", 32'(snap_sel), 32'(0));
        check("mid_rst_mvalid", 32'(snap_mvalid), 32'(0));
        check("mid_rst_r1", 32'(snap_r1), 32'(0));
        step(1'b0);
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);
        check("restart_sel", 32'(snap_sel), 32'(0));
        check("restart_data", 32'(snap_mdata), 32'h00);
        run_until("restart_done", 8, 30);
        exp_q = {8'h80, 8'h81, 8'h82, 8'h00, 8'h01, 8'h83, 8'h84, 8'h85};
        check_seq("restart_seq", exp_q);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
